pq_minmax_sorted: RTL and testbench

//  Parametrised double-ended priority queue: sorted register array, one enqueue, dequeue-min,

---
 rtl/pq_minmax_sorted_pkg.sv | 22 ++
 rtl/pq_minmax_sorted_if.sv | 39 +++
 rtl/pq_minmax_sorted_cell.sv | 41 ++++
 rtl/pq_minmax_sorted.sv | 182 ++++++++++++++++++
 tb/tb_pq_minmax_sorted.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pq_minmax_sorted_pkg.sv
// Shared types for the sorted min/max priority queue.
// Default widths match the header parser key and the ring-slot NoF tag.
package pq_minmax_sorted_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_KEY_W = 32;
  localparam int DEF_NOF_W = 16;

  typedef enum logic [1:0] {
    ENQUE     = 2'd0,
    DEQUE_MIN = 2'd1,
    DEQUE_MAX = 2'd2,
    PEEK      = 2'd3
  } pq_op_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_NOF_W-1:0] nof;
    logic [DEF_KEY_W-1:0] key;
  } pq_entry_t;

endpackage

// File: rtl/pq_minmax_sorted_if.sv
// Op request / result bundle between the parser, the queue
// and the slot scheduler.
interface pq_minmax_sorted_if #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 32,
  parameter int NOF_W = 16
);
  import pq_minmax_sorted_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic             op_valid;
  pq_op_t           op;
  logic [KEY_W-1:0] in_key;
  logic [NOF_W-1:0] in_nof;
  logic             out_valid;
  logic [KEY_W-1:0] out_key;
  logic [NOF_W-1:0] out_nof;
  logic             out_err;
  logic             out_evict;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    output op_valid, op, in_key, in_nof,
    input  out_valid, out_key, out_nof,
    input  out_err, out_evict,
    input  count, full, empty
  );

  modport slave (
    input  op_valid, op, in_key, in_nof,
    output out_valid, out_key, out_nof,
    output out_err, out_evict,
    output count, full, empty
  );

endinterface

// File: rtl/pq_minmax_sorted_cell.sv
// One slot of the sorted array: loads a new entry or a
// neighbour, or clears, as told by the top.
module pq_minmax_sorted_cell #(
  parameter int EW = 49
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [EW-1:0] left_i,
  input  logic [EW-1:0] right_i,
  input  logic [EW-1:0] new_i,
  input  logic          ins_i,
  input  logic          up_i,
  input  logic          dn_i,
  input  logic          clr_i,
  output logic [EW-1:0] ent_o
);

  logic [EW-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    unique case (1'b1)
      clr_i:   ent_d = '0;
      ins_i:   ent_d = new_i;
      up_i:    ent_d = left_i;
      dn_i:    ent_d = right_i;
      default: ent_d = ent_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/pq_minmax_sorted.sv
// Double-ended priority queue over a sorted register array:
// one enqueue, dequeue-min, dequeue-max or peek per cycle.
module pq_minmax_sorted
  import pq_minmax_sorted_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int KEY_W     = DEF_KEY_W,
  parameter int NOF_W     = DEF_NOF_W,
  parameter int EVICT_MAX = 1
) (
  input logic               clk,
  input logic               rst_n,
  pq_minmax_sorted_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int EW = 1 + NOF_W + KEY_W;

  typedef struct packed {
    logic             valid;
    logic [NOF_W-1:0] nof;
    logic [KEY_W-1:0] key;
  } ent_t;

  ent_t ents [DEPTH];
  ent_t lft  [DEPTH];
  ent_t rgt  [DEPTH];
  ent_t new_e;
  ent_t max_e;

  logic [DEPTH-1:0] gt;
  logic [DEPTH-1:0] ins_v, up_v, dn_v, clr_v;
  logic [CW-1:0]    ins_idx;
  logic [IW-1:0]    last_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty;

  logic             out_valid_q;
  logic             out_err_q, out_err_d;
  logic             out_evict_q, out_evict_d;
  logic [KEY_W-1:0] out_key_q, out_key_d;
  logic [NOF_W-1:0] out_nof_q, out_nof_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    if (g == 0) begin : g_lo
      assign lft[g] = '0;
    end else begin : g_lo
      assign lft[g] = ents[g-1];
    end
    if (g == DEPTH - 1) begin : g_hi
      assign rgt[g] = '0;
    end else begin : g_hi
      assign rgt[g] = ents[g+1];
    end

    pq_minmax_sorted_cell #(.EW(EW)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .left_i  (lft[g]),
      .right_i (rgt[g]),
      .new_i   (new_e),
      .ins_i   (ins_v[g]),
      .up_i    (up_v[g]),
      .dn_i    (dn_v[g]),
      .clr_i   (clr_v[g]),
      .ent_o   (ents[g])
    );
  end

  // gt is a thermometer over the valid prefix; its first 1 is the slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      gt[i] = ents[i].valid && (ents[i].key > bus.in_key);
    end
    ins_idx = cnt_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (gt[i]) ins_idx = CW'(i);
    end
  end

  assign last_idx = IW'(cnt_q - 1'b1);
  assign max_e    = ents[last_idx];
  assign new_e    = '{valid: 1'b1, nof: bus.in_nof, key: bus.in_key};

  always_comb begin
    cnt_d       = cnt_q;
    ins_v       = '0;
    up_v        = '0;
    dn_v        = '0;
    clr_v       = '0;
    out_err_d   = 1'b0;
    out_evict_d = 1'b0;
    out_key_d   = '0;
    out_nof_d   = '0;
    if (bus.op_valid) begin
      unique case (bus.op)
        ENQUE: begin
          if (!full || (EVICT_MAX != 0 && bus.in_key < max_e.key)) begin
            for (int i = 0; i < DEPTH; i++) begin
              ins_v[i] = (CW'(i) == ins_idx);
              up_v[i]  = (CW'(i) > ins_idx) && (CW'(i) <= cnt_q);
            end
            if (full) begin
              out_evict_d = 1'b1;
              out_key_d   = max_e.key;
              out_nof_d   = max_e.nof;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            out_err_d = 1'b1;
          end
        end
        DEQUE_MIN: begin
          if (empty) begin
            out_err_d = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              dn_v[i] = (CW'(i) < cnt_q);
            end
            out_key_d = ents[0].key;
            out_nof_d = ents[0].nof;
            cnt_d     = cnt_q - 1'b1;
          end
        end
        DEQUE_MAX: begin
          if (empty) begin
            out_err_d = 1'b1;
          end else begin
            clr_v[last_idx] = 1'b1;
            out_key_d       = max_e.key;
            out_nof_d       = max_e.nof;
            cnt_d           = cnt_q - 1'b1;
          end
        end
        PEEK: begin
          if (empty) begin
            out_err_d = 1'b1;
          end else begin
            out_key_d = ents[0].key;
            out_nof_d = ents[0].nof;
          end
        end
        default: out_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_evict_q <= 1'b0;
      out_key_q   <= '0;
      out_nof_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= bus.op_valid;
      out_err_q   <= out_err_d;
      out_evict_q <= out_evict_d;
      if (bus.op_valid) begin
        out_key_q <= out_key_d;
        out_nof_q <= out_nof_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_evict = out_evict_q;
  assign bus.out_key   = out_key_q;
  assign bus.out_nof   = out_nof_q;
  assign bus.count     = cnt_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_pq_minmax_sorted.sv
// Directed bench for pq_minmax_sorted: evicting instance (a)
// and rejecting instance (b), DEPTH=4, 8-bit keys, 4-bit NoF.
module tb_pq_minmax_sorted;
  import pq_minmax_sorted_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   npass = 0;
  int   ntot = 0;

  always #5 clk = ~clk;

  pq_minmax_sorted_if #(.DEPTH(4), .KEY_W(8), .NOF_W(4)) a ();
  pq_minmax_sorted_if #(.DEPTH(4), .KEY_W(8), .NOF_W(4)) b ();

  pq_minmax_sorted #(
    .DEPTH(4), .KEY_W(8), .NOF_W(4), .EVICT_MAX(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  pq_minmax_sorted #(
    .DEPTH(4), .KEY_W(8), .NOF_W(4), .EVICT_MAX(0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic op_a(input pq_op_t o, input int k, input int n);
    a.op_valid = 1'b1;
    a.op       = o;
    a.in_key   = 8'(k);
    a.in_nof   = 4'(n);
    @(posedge clk);
    #1;
    a.op_valid = 1'b0;
  endtask

  task automatic op_b(input pq_op_t o, input int k, input int n);
    b.op_valid = 1'b1;
    b.op       = o;
    b.in_key   = 8'(k);
    b.in_nof   = 4'(n);
    @(posedge clk);
    #1;
    b.op_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int k, input int n,
                         input int err, input int ev);
    chk({tag, "_valid"}, 32'(a.out_valid), 1);
    chk({tag, "_key"}, 32'(a.out_key), 32'(k));
    chk({tag, "_nof"}, 32'(a.out_nof), 32'(n));
    chk({tag, "_err"}, 32'(a.out_err), 32'(err));
    chk({tag, "_evict"}, 32'(a.out_evict), 32'(ev));
  endtask

  initial begin
    a.op_valid = 1'b0; a.op = ENQUE; a.in_key = '0; a.in_nof = '0;
    b.op_valid = 1'b0; b.op = ENQUE; b.in_key = '0; b.in_nof = '0;
    idle();
    idle();
    chk("rst_count", 32'(a.count), 0);
    chk("rst_empty", 32'(a.empty), 1);
    chk("rst_full", 32'(a.full), 0);
    chk("rst_valid", 32'(a.out_valid), 0);
    chk("rst_key", 32'(a.out_key), 0);
    chk("rst_err", 32'(a.out_err), 0);
    chk("rst_evict", 32'(a.out_evict), 0);
    rst_n = 1'b1;
    idle();

    // 1: unordered inserts come out ascending
    op_a(ENQUE, 30, 1);
    chk_out("t1_enq", 0, 0, 0, 0);
    op_a(ENQUE, 10, 2);
    op_a(ENQUE, 20, 3);
    chk("t1_count", 32'(a.count), 3);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t1_d0", 10, 2, 0, 0);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t1_d1", 20, 3, 0, 0);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t1_d2", 30, 1, 0, 0);
    chk("t1_empty", 32'(a.empty), 1);

    // 2: ties keep arrival order
    op_a(ENQUE, 5, 1);
    op_a(ENQUE, 5, 2);
    op_a(ENQUE, 5, 3);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t2_min", 5, 1, 0, 0);
    op_a(DEQUE_MAX, 0, 0);
    chk_out("t2_max", 5, 3, 0, 0);
    chk("t2_count", 32'(a.count), 1);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t2_last", 5, 2, 0, 0);

    // 3: full queue eviction and rejection
    op_a(ENQUE, 10, 1);
    op_a(ENQUE, 20, 2);
    op_a(ENQUE, 30, 3);
    op_a(ENQUE, 40, 4);
    chk("t3_full", 32'(a.full), 1);
    op_a(ENQUE, 15, 7);
    chk_out("t3_evict", 40, 4, 0, 1);
    chk("t3_count", 32'(a.count), 4);
    op_a(ENQUE, 50, 9);
    chk("t3_rej_err", 32'(a.out_err), 1);
    chk("t3_rej_ev", 32'(a.out_evict), 0);
    chk("t3_rej_cnt", 32'(a.count), 4);
    op_a(DEQUE_MAX, 0, 0);
    chk_out("t3_max", 30, 3, 0, 0);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t3_q0", 10, 1, 0, 0);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t3_q1", 15, 7, 0, 0);
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t3_q2", 20, 2, 0, 0);
    chk("t3_empty", 32'(a.empty), 1);

    // 4: reject policy on instance b
    op_b(ENQUE, 10, 1);
    op_b(ENQUE, 20, 2);
    op_b(ENQUE, 30, 3);
    op_b(ENQUE, 40, 4);
    op_b(ENQUE, 1, 5);
    chk("t4_valid", 32'(b.out_valid), 1);
    chk("t4_err", 32'(b.out_err), 1);
    chk("t4_evict", 32'(b.out_evict), 0);
    chk("t4_count", 32'(b.count), 4);
    op_b(PEEK, 0, 0);
    chk("t4_peek", 32'(b.out_key), 10);
    op_b(DEQUE_MAX, 0, 0);
    chk("t4_max", 32'(b.out_key), 40);

    // 5: empty-queue errors, peek, hold on idle
    op_a(DEQUE_MIN, 0, 0);
    chk_out("t5_dmin", 0, 0, 1, 0);
    op_a(DEQUE_MAX, 0, 0);
    chk_out("t5_dmax", 0, 0, 1, 0);
    op_a(PEEK, 0, 0);
    chk_out("t5_peek", 0, 0, 1, 0);
    chk("t5_count0", 32'(a.count), 0);
    op_a(ENQUE, 9, 5);
    op_a(PEEK, 0, 0);
    chk_out("t5_pk9", 9, 5, 0, 0);
    chk("t5_count1", 32'(a.count), 1);
    idle();
    chk("t5_idle_v", 32'(a.out_valid), 0);
    chk("t5_idle_key", 32'(a.out_key), 9);
    op_a(DEQUE_MAX, 0, 0);
    chk_out("t5_dq9", 9, 5, 0, 0);

    // 6: back-to-back ops, then reset with an op pending
    op_a(ENQUE, 8, 1);
    op_a(DEQUE_MAX, 0, 0);
    chk_out("t6_max", 8, 1, 0, 0);
    op_a(ENQUE, 3, 2);
    chk("t6_count1", 32'(a.count), 1);
    op_a(ENQUE, 4, 3);
    op_a(ENQUE, 6, 4);
    chk("t6_count3", 32'(a.count), 3);
    rst_n      = 1'b0;
    a.op_valid = 1'b1;
    a.op       = ENQUE;
    a.in_key   = 8'd7;
    a.in_nof   = 4'd1;
    @(posedge clk);
    #1;
    a.op_valid = 1'b0;
    chk("t6_rst_cnt", 32'(a.count), 0);
    chk("t6_rst_v", 32'(a.out_valid), 0);
    rst_n = 1'b1;
    idle();
    chk("t6_post_v", 32'(a.out_valid), 0);
    chk("t6_post_e", 32'(a.empty), 1);
    op_a(PEEK, 0, 0);
    chk_out("t6_post_pk", 0, 0, 1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
